voxel_mem_arbiter: RTL and testbench
====================================

# voxel_mem_arbiter

Sequencer and arbiter for the single port of the voxel block store (the L3 world BRAM). After reset it clears the whole store to air and raises `init_done_out`. It then shares the port between one writer (the UART world-stream decoder) and `NUM_REQ` readers (the ray-traversal units under the orchestrator). Each cycle it grants at most one access and returns read data to the requester that issued it, with fixed latency.

## Interface
Parameters:
- `NUM_REQ`, 2: number of read requesters.
- `LENGTH`, 64: x extent; power of two.
- `WIDTH`, 64: y extent; power of two.
- `HEIGHT`, 16: z extent; power of two.
- `BLOCK_BITS`, 5: width of a stored block.
- `READ_LATENCY`, 2: memory cycles from `mem_en_out` (read) to valid `mem_dout_in`; ≥1.
- `STARVE_LIMIT`, 4: maximum consecutive write grants while any read is pending.

Ports (XB=$clog2(LENGTH), YB=$clog2(WIDTH), ZB=$clog2(HEIGHT), AB=XB+YB+ZB):
- `clk_in`, in, 1: single clock.
- `rst_in`, in, 1: synchronous reset, active-low.
- `wr_valid_in`, in, 1: write request.
- `wr_ready_out`, out, 1: write accepted this cycle.
- `wr_x_in` / `wr_y_in` / `wr_z_in`, in, XB/YB/ZB: write coordinates.
- `wr_data_in`, in, BLOCK_BITS: block to store.
- `rd_valid_in`, in, NUM_REQ: per-reader request.
- `rd_ready_out`, out, NUM_REQ: one-hot grant; request accepted this cycle.
- `rd_x_in` / `rd_y_in` / `rd_z_in`, in, NUM_REQ*XB/YB/ZB: packed coordinates; reader i occupies slice i.
- `resp_valid_out`, out, NUM_REQ: one-hot response strobe.
- `resp_data_out`, out, BLOCK_BITS: response block; shared by all readers.
- `init_done_out`, out, 1: clear sweep complete.
- `mem_en_out`, `mem_we_out`, out, 1: memory port enable and write enable.
- `mem_addr_out`, out, AB: memory address.
- `mem_din_out`, out, BLOCK_BITS: write data.
- `mem_dout_in`, in, BLOCK_BITS: read data.

## Operation
- Address: `{z, y, x}` concatenation, i.e. z*LENGTH*WIDTH + y*LENGTH + x. No bounds check is needed; widths are exact.
- States are CLEAR and RUN. Reset enters CLEAR.
- CLEAR:
  - Writes 0 to addresses 0 … DEPTH-1, one per cycle.
  - All `*_ready_out` are held 0.
  - After the write to address DEPTH-1 is issued: go to RUN and set `init_done_out`=1.
- RUN, one grant per cycle:
  - A write is granted if `wr_valid_in` is high, unless the starvation counter equals `STARVE_LIMIT` and a read is pending.
  - Otherwise, a read is granted round-robin. The search starts at index (last granted reader + 1) mod NUM_REQ. The last-granted pointer resets to NUM_REQ-1, so reader 0 wins first.
- Starvation counter:
  - Increments on a write grant while any `rd_valid_in` bit is high.
  - Clears on any read grant, or when no read is pending.
  - Saturates at `STARVE_LIMIT`.
- Ready outputs are combinational from the valids and the state. A handshake is valid&&ready in the same cycle. A requester holds valid and coordinates stable until it sees ready.
- Readers cannot back-pressure responses; every response must be consumed.

## Timing
- Reset values: all `*_ready_out`, `resp_valid_out`, `mem_en_out`, `mem_we_out` and `init_done_out` = 0; `mem_addr_out`, `mem_din_out` and `resp_data_out` = 0. All in-flight response tags are flushed.
- Memory port signals are registered. A handshake in cycle t drives `mem_en_out`, `mem_addr_out`, `mem_we_out` and `mem_din_out` in cycle t+1.
- Reads:
  - A 1+READ_LATENCY-deep tag pipe (valid plus reader index) is advanced every cycle.
  - `resp_valid_out[i]` is high in cycle t+1+READ_LATENCY. With defaults, that is 3 cycles after the handshake.
  - `resp_data_out` equals `mem_dout_in` whenever a response strobe is high.
- Throughput: one access per cycle, so back-to-back responses are legal.
- CLEAR duration: the first clear write appears 1 cycle after reset deasserts. `init_done_out` rises 1 cycle after the last clear write appears, i.e. DEPTH+1 cycles after reset deasserts. Before that, no `ready_out` bit is asserted.
- Read after write to the same address, one cycle apart, returns the new data. This holds because the memory port is single and in order.
- Reset asserted mid-operation drops every pending response; no strobe is emitted afterwards. Reset asserted mid-CLEAR restarts the sweep at address 0.

## Test plan
- LENGTH=4, WIDTH=4, HEIGHT=2, reset released -> 32 consecutive writes of 0 to addresses 0..31; `init_done_out` rises at cycle 33; no `ready_out` before that.
- Write (1,2,1)=5'd7, then reader 1 reads (1,2,1) -> `mem_addr_out`=25; `resp_valid_out`=2'b10 with data 7 exactly 3 cycles after the read handshake.
- Both readers hold valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses arrive in the same order, one per cycle.
- Writer and reader 0 both valid continuously, STARVE_LIMIT=4 -> grant pattern W,W,W,W,R repeats.
- Reset asserted for 1 cycle, 1 cycle after a read handshake -> no `resp_valid_out` afterwards; CLEAR restarts at address 0.
- Writer valid only, readers idle, 10 cycles -> 10 writes in 10 consecutive cycles; starvation counter stays 0.

Source files
------------

// File: rtl/voxel_mem_arbiter.sv
// voxel_mem_arbiter: clears the voxel store after reset, then arbitrates its single port
// between one writer and NUM_REQ round-robin readers with fixed-latency read responses.
module voxel_mem_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int LENGTH       = 64,
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 16,
  parameter int BLOCK_BITS   = 5,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int XB = $clog2(LENGTH),
  localparam int YB = $clog2(WIDTH),
  localparam int ZB = $clog2(HEIGHT),
  localparam int AB = XB + YB + ZB
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    wr_valid_in,
  output logic                    wr_ready_out,
  input  logic [XB-1:0]           wr_x_in,
  input  logic [YB-1:0]           wr_y_in,
  input  logic [ZB-1:0]           wr_z_in,
  input  logic [BLOCK_BITS-1:0]   wr_data_in,
  input  logic [NUM_REQ-1:0]      rd_valid_in,
  output logic [NUM_REQ-1:0]      rd_ready_out,
  input  logic [NUM_REQ*XB-1:0]   rd_x_in,
  input  logic [NUM_REQ*YB-1:0]   rd_y_in,
  input  logic [NUM_REQ*ZB-1:0]   rd_z_in,
  output logic [NUM_REQ-1:0]      resp_valid_out,
  output logic [BLOCK_BITS-1:0]   resp_data_out,
  output logic                    init_done_out,
  output logic                    mem_en_out,
  output logic                    mem_we_out,
  output logic [AB-1:0]           mem_addr_out,
  output logic [BLOCK_BITS-1:0]   mem_din_out,
  input  logic [BLOCK_BITS-1:0]   mem_dout_in
);
  localparam int DEPTH = LENGTH * WIDTH * HEIGHT;
  localparam int IB = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int SB = $clog2(STARVE_LIMIT + 1);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  logic [0:0] state;
  logic [AB-1:0] clr_addr, rd_addr;
  logic [SB-1:0] starve;
  logic [IB-1:0] last, sel;
  logic found, pend, run, wr_hs, rd_hs;
  logic [READ_LATENCY:0] tag_v;
  logic [IB-1:0] tag_i [READ_LATENCY+1];
  int j;
  always_comb begin
    run = rst_in && init_done_out;
    pend = |rd_valid_in;
    wr_hs = run && wr_valid_in && !(starve == SB'(STARVE_LIMIT) && pend);
    sel = last;
    found = 1'b0;
    j = 0;
    // Search starts just past the last granted reader.
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!found && rd_valid_in[j]) begin
        found = 1'b1;
        sel = IB'(j);
      end
    end
    rd_hs = run && !wr_hs && found;
    rd_addr = {rd_z_in[sel*ZB +: ZB], rd_y_in[sel*YB +: YB], rd_x_in[sel*XB +: XB]};
    wr_ready_out = wr_hs;
    rd_ready_out = rd_hs ? NUM_REQ'(1) << sel : '0;
    resp_valid_out = tag_v[READ_LATENCY] ? NUM_REQ'(1) << tag_i[READ_LATENCY] : '0;
    resp_data_out = tag_v[READ_LATENCY] ? mem_dout_in : '0;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= CLEAR;
      clr_addr <= '0;
      starve <= '0;
      last <= IB'(NUM_REQ - 1);
      init_done_out <= 1'b0;
      mem_en_out <= 1'b0;
      mem_we_out <= 1'b0;
      mem_addr_out <= '0;
      mem_din_out <= '0;
      tag_v <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) tag_i[i] <= '0;
    end else begin
      tag_v <= {tag_v[READ_LATENCY-1:0], rd_hs};
      tag_i[0] <= sel;
      for (int i = 1; i <= READ_LATENCY; i++) tag_i[i] <= tag_i[i-1];
      init_done_out <= state == RUN;
      if (state == CLEAR) begin
        mem_en_out <= 1'b1;
        mem_we_out <= 1'b1;
        mem_addr_out <= clr_addr;
        mem_din_out <= '0;
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == AB'(DEPTH - 1)) state <= RUN;
      end else begin
        mem_en_out <= wr_hs || rd_hs;
        mem_we_out <= wr_hs;
        mem_addr_out <= wr_hs ? {wr_z_in, wr_y_in, wr_x_in} : rd_addr;
        mem_din_out <= wr_hs ? wr_data_in : '0;
      end
      starve <= wr_hs && pend ? (starve == SB'(STARVE_LIMIT) ? starve : starve + 1'b1)
              : (rd_hs || !pend ? '0 : starve);
      if (rd_hs) last <= sel;
    end
  end
endmodule

// File: tb/tb_voxel_mem_arbiter.sv
// tb_voxel_mem_arbiter: randomized requesters against a spec-level grant/world model,
// with a response scoreboard drained by an independent monitor.
module tb_voxel_mem_arbiter;
  localparam int N = 2, L = 4, W = 4, H = 2, BB = 5, RL = 2, LIM = 4;
  localparam int XB = 2, YB = 2, ZB = 1, AB = 5, DEPTH = L * W * H;
  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic wr_valid_in = 1'b0, wr_ready_out;
  logic [XB-1:0] wr_x_in = '0;
  logic [YB-1:0] wr_y_in = '0;
  logic [ZB-1:0] wr_z_in = '0;
  logic [BB-1:0] wr_data_in = '0;
  logic [N-1:0] rd_valid_in = '0, rd_ready_out, resp_valid_out;
  logic [N*XB-1:0] rd_x_in = '0;
  logic [N*YB-1:0] rd_y_in = '0;
  logic [N*ZB-1:0] rd_z_in = '0;
  logic [BB-1:0] resp_data_out, mem_din_out, mem_dout_in;
  logic init_done_out, mem_en_out, mem_we_out;
  logic [AB-1:0] mem_addr_out;
  voxel_mem_arbiter #(.NUM_REQ(N), .LENGTH(L), .WIDTH(W), .HEIGHT(H), .BLOCK_BITS(BB),
    .READ_LATENCY(RL), .STARVE_LIMIT(LIM)) dut (
    .clk_in(clk), .rst_in(rst_in), .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
    .wr_x_in(wr_x_in), .wr_y_in(wr_y_in), .wr_z_in(wr_z_in), .wr_data_in(wr_data_in),
    .rd_valid_in(rd_valid_in), .rd_ready_out(rd_ready_out), .rd_x_in(rd_x_in),
    .rd_y_in(rd_y_in), .rd_z_in(rd_z_in), .resp_valid_out(resp_valid_out),
    .resp_data_out(resp_data_out), .init_done_out(init_done_out), .mem_en_out(mem_en_out),
    .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_din_out(mem_din_out),
    .mem_dout_in(mem_dout_in));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Two-stage block RAM standing in for the world store.
  logic [BB-1:0] bram [DEPTH];
  logic [BB-1:0] q1, q2;
  always @(posedge clk) begin
    if (mem_en_out && mem_we_out) bram[mem_addr_out] <= mem_din_out;
    if (mem_en_out && !mem_we_out) q1 <= bram[mem_addr_out];
    q2 <= q1;
  end
  assign mem_dout_in = q2;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  typedef struct { int due; int who; logic [BB-1:0] data; } exp_t;
  exp_t sb [$];
  int k = 0, m_last = N - 1, m_starve = 0, rg;
  logic wg, pend, run_ok;
  logic n_en = 1'b0, n_we = 1'b0;
  logic [AB-1:0] n_addr = '0, a;
  logic [BB-1:0] n_din = '0;
  logic [BB-1:0] world [DEPTH];
  function automatic logic [AB-1:0] raddr(input int i);
    return {rd_z_in[i*ZB +: ZB], rd_y_in[i*YB +: YB], rd_x_in[i*XB +: XB]};
  endfunction
  // Reference: predicts this cycle's grant and next cycle's memory port from the rules.
  always @(negedge clk) begin
    chk("mem_en", mem_en_out, n_en);
    if (n_en) begin
      chk("mem_we", mem_we_out, n_we);
      chk("mem_addr", mem_addr_out, n_addr);
      if (n_we) chk("mem_din", mem_din_out, n_din);
    end
    chk("init_done", init_done_out, k >= DEPTH + 1);
    pend = |rd_valid_in;
    run_ok = rst_in && k >= DEPTH + 1;
    wg = run_ok && wr_valid_in && !(m_starve == LIM && pend);
    rg = -1;
    if (run_ok && !wg)
      for (int j = 1; j <= N; j++)
        if (rg < 0 && rd_valid_in[(m_last + j) % N]) rg = (m_last + j) % N;
    chk("wr_ready", wr_ready_out, wg);
    chk("rd_ready", rd_ready_out, rg < 0 ? 0 : 1 << rg);
    n_en = 1'b0; n_we = 1'b0; n_addr = '0; n_din = '0;
    if (!rst_in) begin
      m_last = N - 1;
      m_starve = 0;
      for (int i = 0; i < DEPTH; i++) world[i] = '0;
      k = 0;
    end else begin
      if (k < DEPTH) begin
        n_en = 1'b1; n_we = 1'b1; n_addr = AB'(k);
      end else if (wg) begin
        a = {wr_z_in, wr_y_in, wr_x_in};
        n_en = 1'b1; n_we = 1'b1; n_addr = a; n_din = wr_data_in;
        world[a] = wr_data_in;
      end else if (rg >= 0) begin
        a = raddr(rg);
        n_en = 1'b1; n_addr = a;
        sb.push_back('{due: cyc + 1 + RL, who: rg, data: world[a]});
      end
      if (run_ok) m_starve = wg && pend ? (m_starve < LIM ? m_starve + 1 : LIM)
                           : (rg >= 0 || !pend ? 0 : m_starve);
      if (rg >= 0) m_last = rg;
      k++;
    end
  end
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("resp_valid", resp_valid_out, 1 << sb[0].who);
      chk("resp_data", resp_data_out, sb[0].data);
      void'(sb.pop_front());
    end else chk("resp_idle", resp_valid_out, 0);
    if (!rst_in) sb.delete();
  end
  task automatic run(input int n, input int pw, input int pr, input logic [N-1:0] mask);
    logic whs;
    logic [N-1:0] rhs;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      whs = wr_valid_in && wr_ready_out;
      rhs = rd_valid_in & rd_ready_out;
      @(posedge clk); #1;
      if (!wr_valid_in || whs) begin
        wr_valid_in = $urandom_range(99) < pw;
        wr_x_in = XB'($urandom); wr_y_in = YB'($urandom); wr_z_in = ZB'($urandom);
        wr_data_in = BB'($urandom);
      end
      for (int i = 0; i < N; i++)
        if (!rd_valid_in[i] || rhs[i]) begin
          rd_valid_in[i] = mask[i] && $urandom_range(99) < pr;
          rd_x_in[i*XB +: XB] = XB'($urandom);
          rd_y_in[i*YB +: YB] = YB'($urandom);
          rd_z_in[i*ZB +: ZB] = ZB'($urandom);
        end
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b1;
    run(DEPTH + 10, 100, 100, 2'b11);
    run(10, 0, 0, 2'b00);
    run(10, 100, 0, 2'b00);
    run(5, 0, 0, 2'b00);
    wr_valid_in = 1'b1; wr_x_in = 2'd1; wr_y_in = 2'd2; wr_z_in = 1'b1; wr_data_in = 5'd7;
    @(posedge clk); #1;
    wr_valid_in = 1'b0;
    rd_valid_in = 2'b10; rd_x_in[3:2] = 2'd1; rd_y_in[3:2] = 2'd2; rd_z_in[1] = 1'b1;
    @(posedge clk); #1;
    rd_valid_in = '0;
    run(5, 0, 0, 2'b00);
    run(12, 0, 100, 2'b11);
    run(5, 0, 0, 2'b00);
    run(30, 100, 100, 2'b01);
    run(800, 40, 40, 2'b11);
    run(400, 90, 70, 2'b11);
    run(8, 0, 0, 2'b00);
    rd_valid_in = 2'b01;
    @(posedge clk); #1;
    rd_valid_in = '0;
    rst_in = 1'b0;
    @(posedge clk); #1;
    rst_in = 1'b1;
    run(DEPTH + 10, 30, 30, 2'b11);
    run(300, 50, 50, 2'b11);
    run(10, 0, 0, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
